// File: rtl/rvsteel_gpio_input_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : rvsteel_gpio_input_filter_if
// Brief    : Memory-mapped IO bus bundle for the GPIO input filter.
// Revision : 1.0 - initial release
// ============================================================================

interface rvsteel_gpio_input_filter_if;
  logic [31:0] rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address, read_request, write_data, write_strobe, write_request,
    input  read_data, read_response, write_response
  );

  modport slave (
    input  rw_address, read_request, write_data, write_strobe, write_request,
    output read_data, read_response, write_response
  );
endinterface

`default_nettype wire

// File: rtl/rvsteel_gpio_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : rvsteel_gpio_input_filter
// Brief    : Per-pin synchronizer, programmable debounce and edge-to-interrupt
//            conditioning for raw GPIO pads, configured over the IO bus.
// Revision : 1.0 - initial release
// ============================================================================

module rvsteel_gpio_input_filter #(
  parameter int GPIO_WIDTH     = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_WIDTH = 16,
  parameter int DEBOUNCE_RESET = 1000
) (
  input  wire                          clock,
  input  wire                          reset,
  rvsteel_gpio_input_filter_if.slave   bus,
  input  wire [GPIO_WIDTH-1:0]         gpio_raw,
  output logic [GPIO_WIDTH-1:0]        gpio_filtered,
  output logic                         irq
);

  localparam logic [DEBOUNCE_WIDTH-1:0] c_limit_reset = DEBOUNCE_WIDTH'(DEBOUNCE_RESET);
  localparam logic [2:0] c_idx_limit   = 3'd0;
  localparam logic [2:0] c_idx_rise_en = 3'd1;
  localparam logic [2:0] c_idx_fall_en = 3'd2;
  localparam logic [2:0] c_idx_pending = 3'd3;
  localparam logic [2:0] c_idx_level   = 3'd4;

  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync_chain;
  logic [GPIO_WIDTH-1:0]     w_sync;
  logic [DEBOUNCE_WIDTH-1:0] r_cnt [GPIO_WIDTH];
  logic [DEBOUNCE_WIDTH-1:0] r_limit;
  logic [GPIO_WIDTH-1:0]     r_filtered_d;
  logic [GPIO_WIDTH-1:0]     r_rise_en;
  logic [GPIO_WIDTH-1:0]     r_fall_en;
  logic [GPIO_WIDTH-1:0]     r_pending;
  logic [GPIO_WIDTH-1:0]     w_set;
  logic [GPIO_WIDTH-1:0]     w_clear;
  logic [2:0]                w_index;
  logic                      w_aligned;
  logic                      w_read_en;
  logic                      w_write_en;
  logic [31:0]               w_read_mux;
  logic                      w_unused_bits;

  assign w_index    = bus.rw_address[4:2];
  assign w_aligned  = (bus.rw_address[1:0] == 2'b00);
  assign w_read_en  = bus.read_request && w_aligned;
  assign w_write_en = bus.write_request && w_aligned && (bus.write_strobe == 4'b1111);
  assign w_unused_bits = &{1'b0, bus.rw_address[31:5], bus.write_data};

  assign w_sync = r_sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync_chain <= '0;
    end else begin
      r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], gpio_raw};
    end
  end

  // Counter stops at LIMIT, so it can never wrap; >= makes a lowered LIMIT take effect at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      gpio_filtered <= '0;
    end else begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        if (w_sync[i] == gpio_filtered[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= r_limit) begin
          gpio_filtered[i] <= w_sync[i];
          r_cnt[i]         <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_set   = (gpio_filtered & ~r_filtered_d & r_rise_en)
                 | (~gpio_filtered & r_filtered_d & r_fall_en);
  assign w_clear = (w_write_en && (w_index == c_idx_pending)) ?
                   bus.write_data[GPIO_WIDTH-1:0] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_filtered_d <= '0;
      r_pending    <= '0;
    end else begin
      r_filtered_d <= gpio_filtered;
      r_pending    <= (r_pending & ~w_clear) | w_set;
    end
  end

  assign irq = |r_pending;

  always_comb begin
    w_read_mux = '0;
    case (w_index)
      c_idx_limit:   w_read_mux[DEBOUNCE_WIDTH-1:0] = r_limit;
      c_idx_rise_en: w_read_mux[GPIO_WIDTH-1:0]     = r_rise_en;
      c_idx_fall_en: w_read_mux[GPIO_WIDTH-1:0]     = r_fall_en;
      c_idx_pending: w_read_mux[GPIO_WIDTH-1:0]     = r_pending;
      c_idx_level:   w_read_mux[GPIO_WIDTH-1:0]     = w_sync;
      default:       w_read_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_limit            <= c_limit_reset;
      r_rise_en          <= '0;
      r_fall_en          <= '0;
      bus.read_data      <= '0;
      bus.read_response  <= 1'b0;
      bus.write_response <= 1'b0;
    end else begin
      bus.read_response  <= bus.read_request;
      bus.write_response <= bus.write_request;
      if (w_read_en) begin
        bus.read_data <= w_read_mux;
      end
      if (w_write_en) begin
        case (w_index)
          c_idx_limit:   r_limit   <= bus.write_data[DEBOUNCE_WIDTH-1:0];
          c_idx_rise_en: r_rise_en <= bus.write_data[GPIO_WIDTH-1:0];
          c_idx_fall_en: r_fall_en <= bus.write_data[GPIO_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rvsteel_gpio_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvsteel_gpio_input_filter
// Brief    : Self-checking bench for the GPIO input filter; bus reads are
//            scored against a queue of expected values.
// Revision : 1.0 - initial release
// ============================================================================

module tb_rvsteel_gpio_input_filter;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] gpio_raw;
  logic [1:0] gpio_filtered;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t q_exp[$];

  rvsteel_gpio_input_filter_if bus_if ();

  rvsteel_gpio_input_filter #(
    .GPIO_WIDTH    (2),
    .SYNC_STAGES   (2),
    .DEBOUNCE_WIDTH(16),
    .DEBOUNCE_RESET(1000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus_if),
    .gpio_raw     (gpio_raw),
    .gpio_filtered(gpio_filtered),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] data,
                           input logic [3:0] strobe, input logic [1:0] off);
    bus_if.rw_address    = {27'd0, idx, off};
    bus_if.write_data    = data;
    bus_if.write_strobe  = strobe;
    bus_if.write_request = 1'b1;
    tick(1);
    bus_if.write_request = 1'b0;
    check_value("wresp", 32'(bus_if.write_response), 32'd1);
  endtask

  task automatic bus_read(input logic [2:0] idx, input logic [1:0] off,
                          input logic [31:0] expected, input string tag);
    exp_t e;
    e.tag   = tag;
    e.value = expected;
    q_exp.push_back(e);
    bus_if.rw_address   = {27'd0, idx, off};
    bus_if.read_request = 1'b1;
    tick(1);
    bus_if.read_request = 1'b0;
  endtask

  // Read data and acknowledge are both valid in the cycle after the request.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1 && bus_if.read_response === 1'b1) begin
      if (q_exp.size() == 0) begin
        check_value("sb_underflow", 32'(q_exp.size()), 32'd1);
      end else begin
        e = q_exp.pop_front();
        check_value(e.tag, bus_if.read_data, e.value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset                = 1'b0;
    gpio_raw             = 2'b00;
    bus_if.rw_address    = '0;
    bus_if.write_data    = '0;
    bus_if.write_strobe  = '0;
    bus_if.write_request = 1'b0;
    bus_if.read_request  = 1'b0;

    // Reset state
    tick(3);
    check_value("rst_filtered", 32'(gpio_filtered), 32'd0);
    check_value("rst_irq",      32'(irq),           32'd0);
    check_value("rst_rdata",    bus_if.read_data,   32'd0);
    check_value("rst_rresp",    32'(bus_if.read_response), 32'd0);
    reset = 1'b1;
    tick(1);
    bus_read(3'd0, 2'd0, 32'd1000, "rst_limit");
    bus_read(3'd1, 2'd0, 32'd0,    "rst_rise_en");
    bus_read(3'd3, 2'd0, 32'd0,    "rst_pending");

    // LIMIT=0: pass-through after SYNC_STAGES+1 cycles
    bus_write(3'd0, 32'd0, 4'hF, 2'd0);
    gpio_raw = 2'b01;
    tick(2);
    check_value("t1_early", 32'(gpio_filtered), 32'd0);
    tick(1);
    check_value("t1_pass",  32'(gpio_filtered), 32'd1);
    check_value("t1_irq",   32'(irq),           32'd0);
    gpio_raw = 2'b00;
    tick(4);
    check_value("t1_back",  32'(gpio_filtered), 32'd0);

    // LIMIT=4: a 4-cycle glitch is rejected, a 6-cycle pulse is accepted
    bus_write(3'd0, 32'd4, 4'hF, 2'd0);
    bus_write(3'd1, 32'd1, 4'hF, 2'd0);
    gpio_raw = 2'b01;
    tick(4);
    gpio_raw = 2'b00;
    tick(10);
    check_value("t2_glitch", 32'(gpio_filtered), 32'd0);
    check_value("t2_glitch_irq", 32'(irq), 32'd0);
    bus_read(3'd3, 2'd0, 32'd0, "t2_glitch_pend");
    gpio_raw = 2'b01;
    tick(6);
    check_value("t2_not_yet", 32'(gpio_filtered), 32'd0);
    gpio_raw = 2'b00;
    tick(1);
    check_value("t2_accept",  32'(gpio_filtered), 32'd1);
    check_value("t2_irq_lag", 32'(irq),           32'd0);
    tick(1);
    check_value("t2_irq",     32'(irq),           32'd1);
    tick(10);
    bus_read(3'd3, 2'd0, 32'd1, "t2_pend");

    // Fall enable, W1C, and set winning over a same-cycle clear
    bus_write(3'd3, 32'd1, 4'hF, 2'd0);
    check_value("t3_clr0_irq", 32'(irq), 32'd0);
    bus_write(3'd2, 32'd2, 4'hF, 2'd0);
    gpio_raw = 2'b10;
    tick(10);
    bus_read(3'd3, 2'd0, 32'd0, "t3_rise_gated");
    gpio_raw = 2'b00;
    tick(10);
    bus_read(3'd3, 2'd0, 32'd2, "t3_fall_pend");
    check_value("t3_fall_irq", 32'(irq), 32'd1);
    bus_write(3'd3, 32'd2, 4'hF, 2'd0);
    check_value("t3_w1c_irq", 32'(irq), 32'd0);
    gpio_raw = 2'b10;
    tick(10);
    gpio_raw = 2'b00;
    tick(7);
    check_value("t3_pre_irq",  32'(irq),           32'd0);
    check_value("t3_pre_filt", 32'(gpio_filtered), 32'd0);
    bus_write(3'd3, 32'd2, 4'hF, 2'd0);
    check_value("t3_set_wins", 32'(irq), 32'd1);
    bus_read(3'd3, 2'd0, 32'd2, "t3_set_wins_pend");
    bus_write(3'd2, 32'd0, 4'hF, 2'd0);
    bus_write(3'd1, 32'd0, 4'hF, 2'd0);
    bus_read(3'd3, 2'd0, 32'd2, "t3_disable_keeps");
    bus_write(3'd3, 32'd3, 4'hF, 2'd0);
    check_value("t3_clr_all", 32'(irq), 32'd0);

    // Lowering LIMIT below a running count
    bus_write(3'd0, 32'd100, 4'hF, 2'd0);
    gpio_raw = 2'b01;
    tick(52);
    check_value("t4_counting", 32'(gpio_filtered), 32'd0);
    bus_write(3'd0, 32'd10, 4'hF, 2'd0);
    check_value("t4_same_edge", 32'(gpio_filtered), 32'd0);
    tick(1);
    check_value("t4_lowered", 32'(gpio_filtered), 32'd1);

    // Bus corner cases
    bus_write(3'd0, 32'd7, 4'b0011, 2'd0);
    bus_read(3'd0, 2'd0, 32'd10, "t5_partial_strobe");
    bus_write(3'd0, 32'd5, 4'hF, 2'd1);
    bus_read(3'd0, 2'd0, 32'd10, "t5_misaligned_wr");
    bus_write(3'd7, 32'hFFFF_FFFF, 4'hF, 2'd0);
    bus_read(3'd7, 2'd0, 32'd0, "t5_idx7");
    bus_read(3'd6, 2'd0, 32'd0, "t5_idx6");
    bus_read(3'd0, 2'd0, 32'd10, "t5_limit");
    bus_read(3'd6, 2'd2, 32'd10, "t5_misaligned_rd");
    bus_read(3'd4, 2'd0, 32'd1, "t5_level_01");
    gpio_raw = 2'b10;
    tick(3);
    bus_read(3'd4, 2'd0, 32'd2, "t5_level_10");
    bus_read(3'd1, 2'd0, 32'd0, "t5_rise_en_kept");

    // Asynchronous reset mid-count with a pending flag
    bus_write(3'd1, 32'd3, 4'hF, 2'd0);
    tick(20);
    check_value("t6_filt", 32'(gpio_filtered), 32'd2);
    check_value("t6_irq",  32'(irq),           32'd1);
    gpio_raw = 2'b01;
    tick(6);
    #2;
    reset = 1'b0;
    #1;
    check_value("t6_async_irq",   32'(irq),           32'd0);
    check_value("t6_async_filt",  32'(gpio_filtered), 32'd0);
    check_value("t6_async_rdata", bus_if.read_data,   32'd0);
    check_value("t6_async_wresp", 32'(bus_if.write_response), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    check_value("t6_post_filt", 32'(gpio_filtered), 32'd0);
    bus_read(3'd0, 2'd0, 32'd1000, "t6_limit_reset");
    bus_read(3'd3, 2'd0, 32'd0,    "t6_pend_reset");
    bus_read(3'd1, 2'd0, 32'd0,    "t6_rise_en_reset");

    tick(2);
    check_value("sb_empty", 32'(q_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
